// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================
// Module  : uart_pkg
// Brief   : Shared UART receiver state encodings and constants
// Revision: 1.0
// ============================================================
package uart_pkg;

    localparam int OVERSAMPLE       = 16;
    localparam int DEFAULT_DVSR_BIT = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================
// Module  : baud_gen
// Brief   : Oversample tick generator, one tick every i_dvsr+1 clocks
// Revision: 1.0
// ============================================================
module baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR_BIT = DEFAULT_DVSR_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    output logic                o_tick
);

    logic [DVSR_BIT-1:0] count_q;
    logic [DVSR_BIT-1:0] count_d;
    logic [DVSR_BIT-1:0] dvsr_q;
    logic [DVSR_BIT-1:0] dvsr_d;
    logic                w_tick;

    // The divisor is captured only at a wrap, so a divisor change can never
    // leave the counter above its terminal value.
    assign w_tick = (count_q == dvsr_q);

    always_comb begin
        count_d = count_q + 1'b1;
        dvsr_d  = dvsr_q;
        if (w_tick) begin
            count_d = '0;
            dvsr_d  = i_dvsr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dvsr_q  <= '0;
        end else begin
            count_q <= count_d;
            dvsr_q  <= dvsr_d;
        end
    end

    assign o_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================
// Module  : uart_rx
// Brief   : 16x oversampling UART receiver, LSB first, with frame-error pulse
// Revision: 1.0
// ============================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BIT = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = DEFAULT_DVSR_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rx,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_rx_done_tick,
    output logic                o_frame_err
);

    localparam int NW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BIT - 1);

    logic                rx_meta_q;
    logic                rx_sync_q;
    logic                w_tick;

    uart_state_e         state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DATA_BIT-1:0] b_q, b_d;
    logic                armed_q, armed_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    baud_gen #(
        .DVSR_BIT (DVSR_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_dvsr (i_dvsr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Armed blocks a held-low line (break or reset mid-frame) from being
    // taken as a stream of new start bits until the line has gone idle.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        armed_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                armed_d = armed_q;
                if (rx_sync_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DATA_BIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        if (rx_sync_q) begin
                            data_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================
// Module  : tb_uart_rx
// Brief   : Scoreboard bench for uart_rx (8N1, 50 MHz clock)
// Revision: 1.0
// ============================================================
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx = 1'b1;
    logic [10:0] i_dvsr = 11'd26;
    logic [7:0]  o_data;
    logic        o_rx_done_tick;
    logic        o_frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int viol_cnt = 0;
    logic prev_done = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    always #10 clk = ~clk;

    uart_rx #(
        .DATA_BIT (8),
        .SB_TICK  (16),
        .DVSR_BIT (11)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rx           (i_rx),
        .i_dvsr         (i_dvsr),
        .o_data         (o_data),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_err    (o_frame_err)
    );

    always @(negedge clk) begin
        if (o_rx_done_tick) begin
            done_cnt <= done_cnt + 1;
            obs_q.push_back(o_data);
        end
        if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
        if ((o_rx_done_tick && o_frame_err) || (o_rx_done_tick && prev_done) ||
            (o_frame_err && prev_ferr))
            viol_cnt <= viol_cnt + 1;
        prev_done <= o_rx_done_tick;
        prev_ferr <= o_frame_err;
    end

    function automatic int bit_time();
        return (int'(i_dvsr) + 1) * 16;
    endfunction

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int bt);
        i_rx = v;
        repeat (bt) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        int bt;
        bt = bit_time();
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
        drive_bit(stop, bt);
        i_rx = 1'b1;
    endtask

    task automatic check_sb(input string name);
        logic [7:0] got;
        logic [7:0] exp;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: unexpected byte got %02h required none", name, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s: byte got %02h required %02h", name, got, exp);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: missing bytes got %0d outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_counts(input string name, input int d0, input int f0,
                                input int dexp, input int fexp);
        n_checks++;
        if (done_cnt - d0 !== dexp) begin
            n_fail++;
            $display("FAIL %s done count: got %0d required %0d", name, done_cnt - d0, dexp);
        end
        n_checks++;
        if (ferr_cnt - f0 !== fexp) begin
            n_fail++;
            $display("FAIL %s frame_err count: got %0d required %0d", name, ferr_cnt - f0, fexp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_rx  = 1'b1;
        idle(5);
        n_checks++;
        if ({o_data, o_rx_done_tick, o_frame_err} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h/%b/%b required 00/0/0",
                     o_data, o_rx_done_tick, o_frame_err);
        end
        rst_n = 1'b1;
        idle(40);
        n_checks++;
        if (dut.state_q !== IDLE || o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL post-reset idle: got state %0d data %h required 0 00",
                     dut.state_q, o_data);
        end
    endtask

    task automatic test_single();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(2 * bit_time());
        check_sb("single_a5");
        check_counts("single_a5", d0, f0, 1, 0);
        n_checks++;
        if (o_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_a5 o_data: got %02h required a5", o_data);
        end
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b1);
        end
        idle(2 * bit_time());
        check_sb("back_to_back");
        check_counts("back_to_back", d0, f0, 9, 0);
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        i_rx = 1'b0;
        idle((int'(i_dvsr) + 1) * 3);
        i_rx = 1'b1;
        idle(2 * bit_time());
        check_counts("glitch", d0, f0, 0, 0);
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL glitch state: got %0d required 0", dut.state_q);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(2 * bit_time());
        check_sb("glitch_3c");
        check_counts("glitch_3c", d0, f0, 1, 0);
    endtask

    task automatic test_frame_err();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        idle(2 * bit_time());
        check_sb("frame_err");
        check_counts("frame_err", d0, f0, 0, 1);
        n_checks++;
        if (o_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL frame_err o_data hold: got %02h required 3c", o_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0, bt;
        bt = bit_time();
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0, bt);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, bt);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_data, o_rx_done_tick, o_frame_err} !== 10'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %h/%b/%b state %0d required 00/0/0 state 0",
                     o_data, o_rx_done_tick, o_frame_err, dut.state_q);
        end
        idle(10);
        rst_n = 1'b1;
        idle(2 * bt);
        check_counts("reset_mid", d0, f0, 0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(2 * bt);
        check_sb("reset_mid_81");
        check_counts("reset_mid_81", d0, f0, 1, 0);
    endtask

    task automatic test_dvsr_zero();
        int d0, f0;
        i_dvsr = 11'd0;
        idle(1000);
        d0 = done_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(2 * bit_time());
        check_sb("dvsr0_7e");
        check_counts("dvsr0_7e", d0, f0, 1, 0);
        n_checks++;
        if (o_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL dvsr0 o_data: got %02h required 7e", o_data);
        end
    endtask

    task automatic test_break();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        i_rx = 1'b0;
        idle(40 * bit_time());
        i_rx = 1'b1;
        idle(2 * bit_time());
        check_sb("break");
        check_counts("break", d0, f0, 0, 1);
        n_checks++;
        if (viol_cnt !== 0) begin
            n_fail++;
            $display("FAIL pulse rules: got %0d violations required 0", viol_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_dvsr_zero();
        test_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8, the number of data bits per frame, sent LSB first.
REQ-002 SHALL have parameter SB_TICK, default 16, the stop-bit length in oversample ticks (16 means 1 stop bit).
REQ-003 SHALL have parameter DVSR_BIT, default 11, the width of the baud divisor.
REQ-004 clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_rx  input  1  asynchronous serial line; idle is high.
REQ-007 i_dvsr  input  DVSR_BIT  oversample divisor; one tick every i_dvsr+1 clk cycles (16 ticks per bit).
REQ-008 o_data  output  DATA_BIT  last correctly received byte.
REQ-009 o_rx_done_tick  output  1  one-cycle pulse when o_data is updated (drives decoder i_data/i_rx_done_tick).
REQ-010 o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 Tick counter SHALL count 0..i_dvsr and assert tick for one cycle when count==i_dvsr, then wrap to 0; i_dvsr=0 gives a tick every cycle.
REQ-013 A new i_dvsr value SHALL take effect at the next counter wrap; behaviour mid-frame after such a change is not guaranteed.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, with a tick count s (0..15) and a bit count n (0..DATA_BIT-1).
REQ-015 IDLE->START SHALL occur when the synced rx is 0 and the armed flag is 1; entry clears s.
REQ-016 Armed flag SHALL set when the synced rx is 1 in IDLE, and clear on leaving IDLE.
REQ-017 START SHALL, on the tick where s==7, sample rx: if 0, go to DATA and clear s and n; if 1, treat it as a glitch and return to IDLE with no output.
REQ-018 DATA SHALL, on the tick where s==15, shift rx into the MSB of a shift register (shift right) and clear s; after bit n==DATA_BIT-1, go to STOP.
REQ-019 STOP SHALL, on the tick where s==SB_TICK-1, sample rx and then go to IDLE:
- rx==1: o_data <= shift register, o_rx_done_tick=1 for one cycle.
- rx==0: o_frame_err=1 for one cycle; o_data and o_rx_done_tick unchanged.
REQ-020 o_rx_done_tick and o_frame_err SHALL never be asserted in the same cycle and SHALL never be high for more than one consecutive cycle.
REQ-021 Latency SHALL be 2 clk cycles of synchronizer delay plus 1 cycle from the stop-sample tick to the done pulse.
REQ-022 A line held low (break) SHALL produce exactly one o_frame_err and no further frames until rx returns high.

Reset
REQ-023 On rst_n low, all of the following SHALL apply immediately, including mid-frame:
- state=IDLE, s=0, n=0, tick counter=0, shift register=0, armed=0;
- o_data=0, o_rx_done_tick=0, o_frame_err=0.
REQ-024 A partial frame in progress at reset SHALL be discarded; reception resumes only after rx is seen high.

Structure
REQ-025 State encodings (2-bit) SHALL live in the shared package uart_pkg, together with OVERSAMPLE=16 and the default DVSR_BIT.
REQ-026 The tick counter SHALL be a sub-module named baud_gen (ports clk, rst_n, i_dvsr, o_tick); the FSM and datapath SHALL stay in uart_rx.

Verification
REQ-027 Use clk 50 MHz, i_dvsr=26, 8N1 frame 0xA5 -> o_data=0xA5, exactly one o_rx_done_tick, no o_frame_err.
REQ-028 Send 9 back-to-back frames 0x01..0x09 with no idle gap -> 9 done pulses, in order, with the correct bytes.
REQ-029 Drive an rx low glitch of 3 ticks -> no done pulse, no error, FSM back in IDLE; the next 0x3C frame is received correctly.
REQ-030 Send frame 0x55 with stop bit 0 -> one o_frame_err pulse, no done pulse, o_data holds its previous value.
REQ-031 Assert rst_n low mid-DATA of frame 0xFF -> all outputs 0; the following 0x81 frame is received correctly.
REQ-032 Set i_dvsr=0 and send frame 0x7E at 16 clk per bit -> o_data=0x7E, one done pulse.
